// File: rtl/conv_pool_stage_pkg.sv
// Shared types and helpers for the conv_pool_stage ReLU + 2x2 max-pool stage.
// Optional feature macro: CONV_POOL_RELU_EN (enables the ReLU activation helper).
package conv_pool_stage_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Signed maximum over the full sample width.
  function automatic logic signed [DATA_W-1:0] max_s(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

`ifdef CONV_POOL_RELU_EN
  // Clamp negative convolution results to zero.
  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction
`endif

endpackage

// File: rtl/conv_pool_stage_pool_line_buf.sv
// Half-row buffer of horizontal partial maxima for the 2x2 pool.
// One synchronous write port and one combinational read port sharing the index c/2.
module pool_line_buf #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Store the even-row partial maximum for the current column pair.
  // NOTE: the storage array has no reset; every entry is written on the even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem[idx_i];

endmodule

// File: rtl/conv_pool_stage.sv
// Streaming ReLU + 2x2/stride-2 max-pool stage: raster-order samples in,
// one pooled value per window out with its linear pooled address.
// Optional feature macro: CONV_POOL_RELU_EN (ReLU before pooling when defined).
module conv_pool_stage #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int DATA_W = conv_pool_stage_pkg::DATA_W,
  parameter int ADDR_W = $clog2((IMG_W/2)*(IMG_H/2))
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              frame_done
);

  import conv_pool_stage_pkg::*;

  localparam int HALF_W = IMG_W / 2;
  localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

  state_e                    state_q;
  logic                      busy_q, frame_done_q;
  logic [CW-1:0]             c_q, c_d;
  logic [RW-1:0]             r_q, r_d;
  logic signed [DATA_W-1:0]  hmax_q, hmax_d;
  logic signed [DATA_W-1:0]  out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]         out_addr_q, out_addr_d;
  logic signed [DATA_W-1:0]  v;
  logic signed [DATA_W-1:0]  lb_rd_data, lb_wr_data;
  logic                      lb_we;
  logic [IDX_W-1:0]          lb_idx;
  logic                      start_ok, in_fire, out_fire, last_in;

  assign start_ok = start && (state_q == IDLE);
  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign last_in  = (c_q == C_LAST) && (r_q == R_LAST);
  assign lb_idx   = IDX_W'(c_q >> 1);

`ifdef CONV_POOL_RELU_EN
  assign v = relu(in_data);
`else
  assign v = in_data;
`endif

  assign lb_wr_data = max_s(hmax_q, v);

  pool_line_buf #(
    .DEPTH  (HALF_W),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_line_buf (
    .clk       (clk),
    .wr_en_i   (lb_we),
    .idx_i     (lb_idx),
    .wr_data_i (lb_wr_data),
    .rd_data_o (lb_rd_data)
  );

  // Frame sequencing with registered busy and frame_done pulse.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (in_fire && last_in) state_q <= DRAIN;
        end
        DRAIN: begin
          if (out_fire) begin
            state_q      <= DONE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Next-state for counters, partial maxima and the output register.
  // NOTE: every signal gets a default first so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    c_d         = c_q;
    r_d         = r_q;
    hmax_d      = hmax_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    lb_we       = 1'b0;

    if (start_ok) begin
      c_d        = '0;
      r_d        = '0;
      out_addr_d = '0;
    end

    // An accepted output frees the register unless a new window lands below.
    if (out_fire) begin
      out_valid_d = 1'b0;
      out_addr_d  = out_addr_q + 1'b1;
    end

    if (in_fire) begin
      if (c_q == C_LAST) begin
        c_d = '0;
        r_d = (r_q == R_LAST) ? '0 : r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end

      case ({r_q[0], c_q[0]})
        2'b00: hmax_d = v;
        2'b01: lb_we  = 1'b1;
        2'b10: hmax_d = max_s(lb_rd_data, v);
        2'b11: begin
          out_data_d  = max_s(hmax_q, v);
          out_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q         <= '0;
      r_q         <= '0;
      hmax_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
    end else begin
      c_q         <= c_d;
      r_q         <= r_d;
      hmax_q      <= hmax_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_pool_stage.sv
// Self-checking bench for conv_pool_stage at IMG_W=IMG_H=4.
// Honours CONV_POOL_RELU_EN in its reference model so it matches either build.
module tb_conv_pool_stage;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int DW   = 32;
  localparam int AW   = 2;
  localparam int N    = W * H;
  localparam int NOUT = N / 4;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, in_ready, out_valid, out_ready, busy, frame_done;
  logic [DW-1:0] in_data, out_data;
  logic [AW-1:0] out_addr;

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] frame [N];
  logic [DW-1:0]        exp_q [$];
  logic [DW-1:0]        got_d [$];
  int                   got_a [$];

  always #5 clk = ~clk;

  conv_pool_stage #(
    .IMG_W  (W),
    .IMG_H  (H),
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] act(input logic signed [DW-1:0] x);
`ifdef CONV_POOL_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  // Reference: the max of the four activated pixels of each 2x2 window, in raster window order.
  task automatic build_expected();
    logic signed [DW-1:0] m, p;
    exp_q.delete();
    for (int pr = 0; pr < H / 2; pr++) begin
      for (int pc = 0; pc < W / 2; pc++) begin
        m = act(frame[(2 * pr) * W + 2 * pc]);
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            p = act(frame[(2 * pr + dy) * W + 2 * pc + dx]);
            if (p > m) m = p;
          end
        end
        exp_q.push_back(m);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},   in_ready,   0);
    check({tag, "_out_valid"},  out_valid,  0);
    check({tag, "_out_data"},   out_data,   0);
    check({tag, "_out_addr"},   out_addr,   0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  // Runs one frame starting at a negedge; drives at negedges and samples 1 time unit later.
  task automatic run_frame(input string tag, input int stall_addr, input int stall_len,
                           input bit rnd, input bit poke_start, input bit chk_rate);
    int            idx = 0, cyc = 0, fd_cnt = 0, fd_cyc = -1, last_hs_cyc = -1;
    int            stall_cnt = 0, first_in = -1, last_in = -1, after = 0;
    bit            prev_stall = 0, run_poked = 0, drain_poked = 0, done = 0;
    logic [DW-1:0] prev_d = '0;
    logic [AW-1:0] prev_a = '0;
    got_d.delete();
    got_a.delete();
    build_expected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 400 && !done) begin
      in_valid = (idx < N) && (!rnd || $urandom_range(0, 3) != 0);
      in_data  = (idx < N) ? frame[idx] : '0;
      start    = 1'b0;
      if (poke_start && !run_poked && idx == 5) begin
        start = 1'b1;
        run_poked = 1;
      end
      if (poke_start && !drain_poked && idx == N && busy) begin
        start = 1'b1;
        drain_poked = 1;
      end
      if (stall_len > 0 && out_valid && int'(out_addr) == stall_addr && stall_cnt < stall_len) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      #1;
      if (prev_stall) begin
        check({tag, "_hold_valid"}, out_valid, 1);
        check({tag, "_hold_data"},  out_data,  prev_d);
        check({tag, "_hold_addr"},  out_addr,  prev_a);
      end
      prev_stall = out_valid && !out_ready;
      if (prev_stall) begin
        check({tag, "_bp_in_ready"}, in_ready, 0);
        prev_d = out_data;
        prev_a = out_addr;
      end
      if (idx == N && last_in >= 0 && cyc == last_in + 1)
        check({tag, "_in_ready_drop"}, in_ready, 0);
      if (frame_done) begin
        fd_cnt++;
        if (fd_cyc < 0) fd_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_a.push_back(int'(out_addr));
        last_hs_cyc = cyc;
      end
      if (in_valid && in_ready) begin
        if (first_in < 0) first_in = cyc;
        last_in = cyc;
        idx++;
      end
      if (fd_cyc >= 0) begin
        after++;
        if (after > 3) done = 1;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    start     = 1'b0;
    check({tag, "_frame_done_seen"},   fd_cyc >= 0, 1);
    check({tag, "_frame_done_count"},  fd_cnt, 1);
    check({tag, "_frame_done_timing"}, fd_cyc, last_hs_cyc + 1);
    check({tag, "_out_count"},         got_d.size(), NOUT);
    for (int k = 0; k < NOUT; k++) begin
      if (k < got_d.size()) begin
        check($sformatf("%s_data%0d", tag, k), got_d[k], exp_q[k]);
        check($sformatf("%s_addr%0d", tag, k), got_a[k], k);
      end
    end
    check({tag, "_busy_after"}, busy, 0);
    if (chk_rate) check({tag, "_throughput"}, last_in - first_in, N - 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    check_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp 0..15 with out_ready held high.
    for (int i = 0; i < N; i++) frame[i] = i;
    run_frame("ramp", -1, 0, 0, 0, 1);

    // Constant negative frame.
    for (int i = 0; i < N; i++) frame[i] = -7;
    run_frame("neg7", -1, 0, 0, 0, 0);

    // Mixed-sign top-left window, ones elsewhere.
    for (int i = 0; i < N; i++) frame[i] = 1;
    frame[0] = -3;
    frame[1] = 9;
    frame[W] = 2;
    frame[W + 1] = -100;
    run_frame("window", -1, 0, 0, 0, 0);

    // Extreme signed values: max positive vs most negative, and an all-minimum window.
    for (int i = 0; i < N; i++) frame[i] = 1;
    frame[0] = 32'sh8000_0000;
    frame[1] = 32'sh7FFF_FFFF;
    frame[W] = 32'sh8000_0000;
    frame[W + 1] = 32'sh8000_0000;
    frame[2] = 32'sh8000_0000;
    frame[3] = 32'sh8000_0000;
    frame[W + 2] = 32'sh8000_0000;
    frame[W + 3] = 32'sh8000_0000;
    run_frame("extreme", -1, 0, 0, 0, 0);

    // Backpressure: hold off addr 1 for five cycles.
    for (int i = 0; i < N; i++) frame[i] = i;
    run_frame("stall", 1, 5, 0, 0, 0);

    // Mid-frame reset with distinct partial data, then a clean ramp frame.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 1000 + i;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 555;
      #1;
      check("norestart_in_ready", in_ready, 0);
      check("norestart_busy", busy, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) frame[i] = i;
    run_frame("postrst", -1, 0, 0, 0, 1);

    // start pulses during RUN and during a stretched DRAIN are ignored.
    run_frame("pokestart", 3, 3, 0, 1, 0);

    // Random frames with random valid gaps and random backpressure.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) frame[i] = $urandom;
      run_frame($sformatf("rand%0d", f), -1, 0, 1, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_pool_stage.md
# conv_pool_stage

Streaming ReLU plus 2x2/stride-2 max-pool stage directly downstream of the 32-input tree adder. Accepts one rounded signed 32-bit convolution result per handshake in raster order and emits one pooled value per 2x2 window, with its linear output address. It buffers half a row of partial maxima, so the layer writer sees a compact pooled stream plus a frame-done pulse.

## Interface
- IMG_W, 64: feature-map width in pixels; even, at least 2.
- IMG_H, 64: feature-map height in pixels; even, at least 2.
- DATA_W, 32: signed sample width; matches the tree-adder result.
- ADDR_W, $clog2((IMG_W/2)*(IMG_H/2)): pooled output address width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that arms a frame; honoured only in IDLE.
- in_valid  in  1  in_data valid.
- in_ready  out  1  stage can accept in_data this cycle.
- in_data  in  DATA_W  signed conv result, raster order.
- out_valid  out  1  pooled sample valid.
- out_ready  in  1  downstream accepts the sample.
- out_data  out  DATA_W  pooled value.
- out_addr  out  ADDR_W  linear pooled index, row*(IMG_W/2)+col.
- busy  out  1  high in RUN and DRAIN.
- frame_done  out  1  one-cycle pulse after the last pooled sample is accepted.

## Operation
- Reset values: in_ready 0, out_valid 0, out_data 0, out_addr 0, busy 0, frame_done 0. State is IDLE and all counters are 0.
- States:
  - IDLE: start goes to RUN and clears counters.
  - RUN: accepts IMG_W*IMG_H samples. Taking the last sample goes to DRAIN.
  - DRAIN: waits for the final out handshake, then goes to DONE.
  - DONE: pulses frame_done for one cycle, then returns to IDLE.
- start outside IDLE is ignored.
- Input handshake fires when in_valid && in_ready. in_ready = (state==RUN) && (!out_valid || out_ready).
- Each accepted sample x is first mapped through the activation: v = ReLU(x) (see Configuration).
- Column counter c runs 0..IMG_W-1. Row counter r runs 0..IMG_H-1. c wraps to 0 and r increments at row end.
- Pooling rules per accepted sample:
  - Even r, even c: hmax <= v.
  - Even r, odd c: line_buf[c/2] <= max(hmax, v).
  - Odd r, even c: hmax <= max(line_buf[c/2], v).
  - Odd r, odd c: out_data <= max(hmax, v); out_valid <= 1.
- All comparisons are signed, full DATA_W.
- Output handshake fires when out_valid && out_ready. It clears out_valid unless a new window completes in the same cycle; in that case out_valid stays 1 and the new data loads.
- out_addr increments after each output handshake and resets to 0 on start.
- line_buf holds IMG_W/2 entries. Its contents are not reset and are always written before being read.

## Timing
- The stage sustains one input per cycle while out_ready is held high.
- Latency: out_valid rises the cycle after the handshake of the odd-row, odd-column sample.
- out_data and out_addr stay stable while out_valid && !out_ready.
- Backpressure: with out_valid high and out_ready low, in_ready is 0 and no sample is lost.
- Frame end: in_ready drops the cycle after the final input. frame_done asserts the cycle after the final out handshake, for exactly one cycle.
- rst_n asserted mid-frame: everything returns to reset values immediately. A partial output is discarded, and the frame restarts only on a new start.

## Configuration
- CONV_POOL_RELU_EN:
  - Defined: v = (x < 0) ? 0 : x, so out_data is never negative.
  - Undefined: v = x and signed max-pool runs on raw values.
- Handshake, timing and addressing are identical either way.

## Structure
- Shared package holds:
  - DATA_W;
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the signed max function;
  - the ReLU function, guarded by the macro.
- One sub-module, pool_line_buf: IMG_W/2 x DATA_W, one synchronous-write port and one combinational-read port, indexed by c/2.
- The FSM, counters and output register live in the top.

## Test plan
Bench parameters are IMG_W=4, IMG_H=4.
- Ramp input 0..15, out_ready held 1 -> out_data 5, 7, 13, 15 at addr 0..3; frame_done one cycle after the 4th handshake.
- All samples -7:
  - with CONV_POOL_RELU_EN -> four outputs of 0;
  - without it -> four outputs of -7.
- Window {-3, 9, 2, -100} at the top-left, all other samples 1 -> addr 0 = 9 (signed compare; 0x7FFF_FFFF vs 0x8000_0000 also checked).
- out_ready low for 5 cycles when addr 1 becomes valid -> in_ready 0, out_data and out_addr held, no sample dropped, final sequence matches the ramp case.
- rst_n pulsed low after sample 6, then start and a full ramp -> outputs 5, 7, 13, 15 at addr 0..3, with no stale line_buf data.
- start pulsed during RUN and during DRAIN -> ignored; exactly 4 outputs and one frame_done.
